// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory and
// captures the fetched word into the IF/ID pipeline register. Supports stall,
// branch/jump redirect with bubble insertion and a retired-fetch counter.
module fetch_stage #(
  parameter int unsigned ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       inst,
  output logic [ADDR_W-1:0] addresIM,
  output logic [31:0]       pc,
  output logic              pc_oob,
  output logic [31:0]       if_id_inst,
  output logic [31:0]       if_id_pc,
  output logic [31:0]       if_id_pc4,
  output logic              if_id_valid,
  output logic [31:0]       fetch_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_inst_q, if_id_inst_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] pc_hi;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-state selection: redirect beats stall, stall beats sequential fetch.
  always_comb begin
    pc_d          = pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    fetch_cnt_d   = fetch_cnt_q;
    if (branch_taken) begin
      // Low two bits of the target are dropped so the PC stays word aligned.
      pc_d          = {branch_target[31:2], 2'b00};
      if_id_inst_d  = NOP_INST;
      if_id_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d          = pc_plus4;
      if_id_inst_d  = inst;
      if_id_pc_d    = pc_q;
      if_id_pc4_d   = pc_plus4;
      if_id_valid_d = 1'b1;
      fetch_cnt_d   = fetch_cnt_q + 32'd1;
    end
  end

  // PC, IF/ID register and fetch counter share one async-reset register block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      if_id_inst_q  <= NOP_INST;
      if_id_pc_q    <= 32'h0;
      if_id_pc4_q   <= 32'h0;
      if_id_valid_q <= 1'b0;
      fetch_cnt_q   <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_cnt_q   <= fetch_cnt_d;
    end
  end

  // IM address and out-of-range flag are decoded straight from the PC.
  always_comb begin
    pc_hi    = pc_q >> (ADDR_W + 2);
    addresIM = pc_q[ADDR_W+1:2];
    pc_oob   = |pc_hi;
  end

  assign pc          = pc_q;
  assign if_id_inst  = if_id_inst_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_valid = if_id_valid_q;
  assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational IM model whose word at
// address a is 32'hC0DE0000 | a.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] inst;
  logic [4:0]  addresIM;
  logic [31:0] pc;
  logic        pc_oob;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_cnt;

  int tests;
  int failed;

  fetch_stage #(
    .ADDR_W  (5),
    .RESET_PC(32'h0000_0000),
    .NOP_INST(NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .inst         (inst),
    .addresIM     (addresIM),
    .pc           (pc),
    .pc_oob       (pc_oob),
    .if_id_inst   (if_id_inst),
    .if_id_pc     (if_id_pc),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .fetch_cnt    (fetch_cnt)
  );

  // IM model: async read.
  assign inst = 32'hC0DE_0000 | {27'b0, addresIM};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] im_word(input logic [31:0] byte_addr);
    return 32'hC0DE_0000 | ((byte_addr >> 2) & 32'h1F);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    rst           = 1'b1;
    #1;
    rst           = 1'b0;
  endtask

  initial begin
    tests         = 0;
    failed        = 0;
    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;

    // Reset values held while rst is high, even across an edge.
    #2;
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", if_id_inst, NOP);
    chk("rst_ifpc", if_id_pc, 32'h0);
    chk("rst_ifpc4", if_id_pc4, 32'h0);
    chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rst_cnt", fetch_cnt, 32'h0);
    chk("rst_addr", {27'b0, addresIM}, 32'h0);
    rst = 1'b0;

    // 1: free-running fetch
    for (int i = 0; i < 8; i++) begin
      chk("run_addr", {27'b0, addresIM}, 32'(i));
      tick();
      chk("run_ifpc", if_id_pc, 32'(4 * i));
      chk("run_ifpc4", if_id_pc4, 32'(4 * i + 4));
      chk("run_inst", if_id_inst, im_word(32'(4 * i)));
      chk("run_valid", {31'b0, if_id_valid}, 32'h1);
    end
    chk("run_cnt", fetch_cnt, 32'd8);
    chk("run_pc", pc, 32'd32);

    // 2: stall at pc=12
    do_reset();
    tick(); tick(); tick();
    chk("pre_stall_pc", pc, 32'd12);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc, 32'd12);
      chk("stall_ifpc", if_id_pc, 32'd8);
      chk("stall_inst", if_id_inst, im_word(32'd8));
      chk("stall_cnt", fetch_cnt, 32'd3);
    end
    stall = 1'b0;
    tick();
    chk("resume_ifpc", if_id_pc, 32'd12);
    chk("resume_pc", pc, 32'd16);
    chk("resume_cnt", fetch_cnt, 32'd4);

    // 3: redirect to 0x40 at pc=16
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    tick();
    branch_taken  = 1'b0;
    chk("br_pc", pc, 32'h40);
    chk("br_addr", {27'b0, addresIM}, 32'd16);
    chk("br_valid", {31'b0, if_id_valid}, 32'h0);
    chk("br_inst", if_id_inst, NOP);
    chk("br_ifpc_hold", if_id_pc, 32'd12);
    chk("br_cnt", fetch_cnt, 32'd4);
    tick();
    chk("br_next_ifpc", if_id_pc, 32'h40);
    chk("br_next_valid", {31'b0, if_id_valid}, 32'h1);
    chk("br_next_inst", if_id_inst, 32'hC0DE_0010);
    chk("br_next_cnt", fetch_cnt, 32'd5);

    // 4: redirect with stall, misaligned target
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_000E;
    tick();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    chk("brst_pc", pc, 32'h0C);
    chk("brst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("brst_inst", if_id_inst, NOP);
    chk("brst_ifpc", if_id_pc, 32'h40);
    tick();
    chk("brst_next_ifpc", if_id_pc, 32'h0C);
    chk("brst_next_pc", pc, 32'h10);

    // 5: wrap past IM size
    branch_taken  = 1'b1;
    branch_target = 32'd120;
    tick();
    branch_taken  = 1'b0;
    chk("wrap_addr30", {27'b0, addresIM}, 32'd30);
    chk("wrap_oob0a", {31'b0, pc_oob}, 32'h0);
    tick();
    chk("wrap_addr31", {27'b0, addresIM}, 32'd31);
    chk("wrap_oob0b", {31'b0, pc_oob}, 32'h0);
    tick();
    chk("wrap_pc128", pc, 32'd128);
    chk("wrap_addr0", {27'b0, addresIM}, 32'd0);
    chk("wrap_oob1", {31'b0, pc_oob}, 32'h1);
    chk("wrap_inst124", if_id_inst, 32'hC0DE_001F);
    tick();
    chk("wrap_ifpc128", if_id_pc, 32'd128);
    chk("wrap_inst128", if_id_inst, 32'hC0DE_0000);
    chk("wrap_valid", {31'b0, if_id_valid}, 32'h1);

    // 6: async reset mid-cycle during a stall
    stall = 1'b1;
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_inst", if_id_inst, NOP);
    chk("arst_ifpc", if_id_pc, 32'h0);
    chk("arst_ifpc4", if_id_pc4, 32'h0);
    chk("arst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("arst_cnt", fetch_cnt, 32'h0);
    chk("arst_oob", {31'b0, pc_oob}, 32'h0);
    #1;
    rst   = 1'b0;
    stall = 1'b0;
    tick();
    chk("restart_ifpc", if_id_pc, 32'h0);
    chk("restart_valid", {31'b0, if_id_valid}, 32'h1);
    chk("restart_pc", pc, 32'h4);
    chk("restart_cnt", fetch_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
